// File: rtl/fir_interpolator.sv
// rtl/fir_interpolator.sv - polyphase interpolating FIR, one shared multiplier
// Each accepted sample yields FACTOR outputs, each a TAPS_PER_PHASE-cycle MAC followed by an EMIT cycle.
module fir_interpolator #(
  parameter int TAPS_PER_PHASE = 8,
  parameter int FACTOR         = 4,
  parameter int BITWIDTH       = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       tick_i,
  input  logic signed [BITWIDTH-1:0] signal_i,
  input  logic signed [BITWIDTH-1:0] coeff [TAPS_PER_PHASE*FACTOR],
  output logic signed [BITWIDTH-1:0] signal_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int PW  = 2 * BITWIDTH;
  localparam int AW  = PW + $clog2(TAPS_PER_PHASE);
  localparam int KW  = (TAPS_PER_PHASE > 1) ? $clog2(TAPS_PER_PHASE) : 1;
  localparam int PHW = $clog2(FACTOR);
  localparam int NC  = TAPS_PER_PHASE * FACTOR;
  localparam int CW  = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_e;

  state_e                     state_q, state_d;
  logic        [KW-1:0]       k_q, k_d;
  logic        [PHW-1:0]      phase_q, phase_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic signed [BITWIDTH-1:0] d_q [TAPS_PER_PHASE];
  logic signed [BITWIDTH-1:0] d_d [TAPS_PER_PHASE];
  logic signed [BITWIDTH-1:0] sig_q, sig_d;
  logic                       valid_q, valid_d;
  logic                       ovr_q, ovr_d;

  logic        [CW-1:0]       cidx;
  logic signed [PW-1:0]       prod;
  logic signed [BITWIDTH-1:0] sat_val;
  logic        [AW-PW+1:0]    acc_top;
  logic                       unused_acc_bits;

  assign cidx    = CW'(int'(k_q) * FACTOR + int'(phase_q));
  assign prod    = d_q[k_q] * coeff[cidx];
  // Top bits all equal means acc fits the Q1 output range after dropping BITWIDTH-1 fraction bits.
  assign acc_top = acc_q[AW-1:PW-2];
  always_comb begin
    sat_val = acc_q[PW-2:BITWIDTH-1];
    if (!((&acc_top) || !(|acc_top))) begin
      sat_val = acc_q[AW-1] ? {1'b1, {(BITWIDTH-1){1'b0}}} : {1'b0, {(BITWIDTH-1){1'b1}}};
    end
  end
  assign unused_acc_bits = ^acc_q[BITWIDTH-2:0];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    d_d     = d_q;
    sig_d   = sig_q;
    valid_d = 1'b0;
    ovr_d   = tick_i && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (tick_i) begin
          for (int i = TAPS_PER_PHASE - 1; i > 0; i--) d_d[i] = d_q[i-1];
          d_d[0]  = signal_i;
          phase_d = '0;
          k_d     = KW'(TAPS_PER_PHASE - 1);
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + AW'(prod);
        k_d   = k_q - 1'b1;
        if (k_q == '0) state_d = EMIT;
      end
      EMIT: begin
        sig_d   = sat_val;
        valid_d = 1'b1;
        if (phase_q == PHW'(FACTOR - 1)) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
          k_d     = KW'(TAPS_PER_PHASE - 1);
          acc_d   = '0;
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      phase_q <= '0;
      acc_q   <= '0;
      d_q     <= '{default: '0};
      sig_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      sig_q   <= sig_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign signal_o  = sig_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;
  assign busy_o    = (state_q != IDLE);

endmodule
